route_req: RTL and testbench
============================

ROUTE_REQ -- requirements
Module: route_req

Interface
REQ-001 Parameter NPORT, 4, number of output ports (2..16); PORTW = clog2(NPORT) derived.
REQ-002 Parameter PKTW, 34, flit width; bits [PKTW-1:PKTW-2] = flow type, bits [DSTW-1:0] = destination.
REQ-003 Parameter DSTW, 2, destination field width (DSTW >= PORTW).
REQ-004 Parameter MODE, 0, 0 = direct decode of destination, 1 = programmable routing table.
REQ-005 Port clk  input  1  single clock; all state on posedge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port pkto  input  PKTW  flit at input-FIFO head.
REQ-008 Port empty  input  1  input FIFO empty; pkto invalid when 1.
REQ-009 Port deq  output  1  FIFO pop, combinational, one flit per cycle.
REQ-010 Port reqo  output  NPORT  one-hot registered request to switch arbiter.
REQ-011 Port gnt  input  NPORT  grant from arbiter, held while request is held.
REQ-012 Port cfg_we  input  1  routing-table write strobe (MODE=1; ignored when MODE=0).
REQ-013 Port cfg_addr  input  DSTW  table entry index.
REQ-014 Port cfg_port  input  PORTW  output port written to entry.
REQ-015 Port drop_cnt  output  8  saturating count of dropped packets and stray flits.

Function
REQ-016 Flow type encoding: 00 NONE, 01 HEAD, 10 BODY, 11 TAIL; packet = HEAD, zero or more BODY, TAIL.
REQ-017 Route lookup: MODE=0 p = dest; MODE=1 p = table[dest]; route is valid only when p < NPORT.
REQ-018 FSM states IDLE, REQ, XFER, DROP.
REQ-019 IDLE, !empty, HEAD, valid route: reqo <= onehot(p) next cycle (1-cycle latency), go REQ, deq = 0.
REQ-020 IDLE, !empty, HEAD, invalid route: deq = 1, drop_cnt++, go DROP; reqo stays 0.
REQ-021 IDLE, !empty, non-HEAD flit: deq = 1 (discard), drop_cnt++, stay IDLE.
REQ-022 REQ/XFER: deq = !empty && |(gnt & reqo); REQ goes XFER on first deq (head transferred).
REQ-023 XFER: deq of TAIL clears reqo next cycle and returns IDLE; next HEAD can raise reqo no earlier than the cycle after that.
REQ-024 Grant removed or FIFO empty mid-packet: deq = 0, reqo held, state unchanged.
REQ-025 Grant on a port other than the requested one is ignored (no deq).
REQ-026 DROP: deq = !empty; dequeued TAIL returns IDLE; no request raised.
REQ-027 drop_cnt saturates at 255; no wrap.
REQ-028 Table write (MODE=1) takes effect next cycle; lookup in the write cycle uses the old entry; writes while mid-packet affect only later HEADs.
REQ-029 reqo is either zero or exactly one-hot at all times.

Reset
REQ-030 rst: state IDLE, reqo = 0, drop_cnt = 0, table[i] = i mod NPORT; deq = 0 in reset cycle.
REQ-031 rst mid-packet abandons the packet; remaining BODY/TAIL flits are discarded as stray per REQ-021 after reset.

Structure
REQ-032 Flow-type constants (NONE/HEAD/BODY/TAIL) and the flow-field bit positions are placed in the shared switch header/package, not redefined locally.
REQ-033 Routing table is one natural sub-module, route_tbl (2^DSTW x PORTW registers, one write port, one async read port); MODE=0 bypasses it.

Verification
REQ-034 NPORT=4, MODE=0: HEAD dest=2, BODY, TAIL, gnt=0100 from cycle 2 -> reqo=0100 one cycle after HEAD, 3 deq pulses, reqo=0000 after TAIL.
REQ-035 Grant withdrawn for 3 cycles after BODY -> deq=0 for those cycles, reqo holds 0100, TAIL then completes.
REQ-036 NPORT=3, MODE=0, HEAD dest=3 -> no reqo, whole packet dequeued, drop_cnt=1.
REQ-037 MODE=1: write table[1]=3, then HEAD dest=1 -> reqo=1000; write in the same cycle as the HEAD lookup -> old entry used.
REQ-038 BODY flit in IDLE x300 -> each discarded, drop_cnt saturates at 255.
REQ-039 rst asserted in XFER -> reqo=0000, drop_cnt=0 next cycle; following stray TAIL discarded, drop_cnt=1.

Source files
------------

// File: rtl/route_req_pkg.sv
// Shared switch definitions: flit flow-type encoding, flow-field placement and
// the route_req FSM state codes.
package route_req_pkg;

  localparam int FLOW_W = 2;

  // Flow field occupies the top FLOW_W bits of a flit: [PKTW-1 : PKTW-2].
  localparam int FLOW_MSB_OFS = 1;

  localparam logic [1:0] FLOW_NONE = 2'b00;
  localparam logic [1:0] FLOW_HEAD = 2'b01;
  localparam logic [1:0] FLOW_BODY = 2'b10;
  localparam logic [1:0] FLOW_TAIL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/route_tbl.sv
// Programmable routing table: destination index -> output port, one write
// port and one asynchronous read port; resets to an identity-modulo map.
module route_tbl
  import route_req_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int DSTW  = 2,
  parameter int PORTW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DSTW-1:0]  waddr,
  input  logic [PORTW-1:0] wdata,
  input  logic [DSTW-1:0]  raddr,
  output logic [PORTW-1:0] rdata
);

  localparam int DEPTH = 1 << DSTW;

  logic [PORTW-1:0] entry [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PORTW'(i % NPORT);
      end
    end else if (we) begin
      entry[waddr] <= wdata;
    end
  end

  assign rdata = entry[raddr];

endmodule

// File: rtl/route_req.sv
// Input-port route computation: looks up the HEAD flit's output port, holds a
// one-hot request to the switch arbiter and pops the FIFO as grants arrive.
module route_req
  import route_req_pkg::*;
#(
  parameter int  NPORT = 4,
  parameter int  PKTW  = 34,
  parameter int  DSTW  = 2,
  parameter int  MODE  = 0,
  localparam int PORTW = $clog2(NPORT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKTW-1:0]  pkto,
  input  logic             empty,
  output logic             deq,
  output logic [NPORT-1:0] reqo,
  input  logic [NPORT-1:0] gnt,
  input  logic             cfg_we,
  input  logic [DSTW-1:0]  cfg_addr,
  input  logic [PORTW-1:0] cfg_port,
  output logic [7:0]       drop_cnt
);

  localparam int DDEPTH = 1 << DSTW;

  logic [1:0]       state;
  logic [1:0]       flow;
  logic [DSTW-1:0]  dest;
  logic [PORTW-1:0] tbl_port;
  logic [DSTW-1:0]  tbl_idx;
  logic [DSTW-1:0]  route_idx;
  logic [PORTW-1:0] route_port;
  logic [DDEPTH-1:0] port_ok;
  logic [NPORT-1:0] req_next;
  logic             route_ok;
  logic             is_head;
  logic             is_tail;
  logic             fwd_fire;
  logic             payload_unused;

  assign flow    = pkto[PKTW-FLOW_MSB_OFS -: FLOW_W];
  assign dest    = pkto[DSTW-1:0];
  assign is_head = (flow == FLOW_HEAD);
  assign is_tail = (flow == FLOW_TAIL);

  assign payload_unused = ^{pkto, route_idx};

  route_tbl #(
    .NPORT (NPORT),
    .DSTW  (DSTW),
    .PORTW (PORTW)
  ) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && (MODE == 1)),
    .waddr (cfg_addr),
    .wdata (cfg_port),
    .raddr (dest),
    .rdata (tbl_port)
  );

  // Index values at or above NPORT name a port that does not exist.
  for (genvar i = 0; i < DDEPTH; i++) begin : g_port_ok
    assign port_ok[i] = (i < NPORT);
  end

  assign tbl_idx    = DSTW'(tbl_port);
  assign route_idx  = (MODE == 1) ? tbl_idx : dest;
  assign route_ok   = port_ok[route_idx];
  assign route_port = route_idx[PORTW-1:0];
  assign req_next   = {{(NPORT-1){1'b0}}, 1'b1} << route_port;

  assign fwd_fire = !empty && (|(gnt & reqo));

  always_comb begin
    deq = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:         deq = !empty && !(is_head && route_ok);
        ST_REQ, ST_XFER: deq = fwd_fire;
        ST_DROP:         deq = !empty;
        default:         deq = 1'b0;
      endcase
    end
  end

  // A HEAD that cannot be routed is counted once; its followers are drained silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      reqo     <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (is_head && route_ok) begin
              reqo  <= req_next;
              state <= ST_REQ;
            end else begin
              drop_cnt <= sat_inc(drop_cnt);
              if (is_head) begin
                state <= ST_DROP;
              end
            end
          end
        end
        ST_REQ: begin
          if (fwd_fire) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (fwd_fire && is_tail) begin
            reqo  <= '0;
            state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (!empty && is_tail) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_req.sv
// Bench for route_req: instance A (NPORT=4, MODE=1) and instance B (NPORT=3, MODE=0),
// each fed from its own flit queue and checked every cycle against a packet-level model.
module tb_route_req;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [1:0]  cfg_port;

  logic [33:0] pkto_a, pkto_b;
  logic        empty_a, empty_b;
  logic        deq_a, deq_b;
  logic [3:0]  reqo_a, gnt_a;
  logic [2:0]  reqo_b, gnt_b;
  logic [7:0]  drop_a, drop_b;

  logic [33:0] qa[$];
  logic [33:0] qb[$];

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;
  bit deq_seen_a = 1'b0;
  bit deq_seen_b = 1'b0;

  // Packet-level model state: owned output port (-1 none), draining flag, head-sent flag.
  int m_port[2] = '{-1, -1};
  bit m_drop[2];
  bit m_head[2];
  int m_cnt[2];
  int m_tbl[2][4];
  int np[2] = '{4, 3};
  int md[2] = '{1, 0};

  route_req #(.NPORT(4), .PKTW(34), .DSTW(2), .MODE(1)) u_a (
    .clk(clk), .rst(rst), .pkto(pkto_a), .empty(empty_a), .deq(deq_a),
    .reqo(reqo_a), .gnt(gnt_a), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_port(cfg_port), .drop_cnt(drop_a)
  );

  route_req #(.NPORT(3), .PKTW(34), .DSTW(2), .MODE(0)) u_b (
    .clk(clk), .rst(rst), .pkto(pkto_b), .empty(empty_b), .deq(deq_b),
    .reqo(reqo_b), .gnt(gnt_b), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_port(cfg_port), .drop_cnt(drop_b)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] flit(input logic [1:0] f, input logic [1:0] d, input int pl);
    return {f, pl[29:0], d};
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    empty_a = (qa.size() == 0);
    pkto_a  = empty_a ? 34'h0 : qa[0];
    empty_b = (qb.size() == 0);
    pkto_b  = empty_b ? 34'h0 : qb[0];
  endtask

  task automatic pushA(input logic [1:0] f, input logic [1:0] d);
    qa.push_back(flit(f, d, qa.size() + 100));
    refresh();
  endtask

  task automatic pushB(input logic [1:0] f, input logic [1:0] d);
    qb.push_back(flit(f, d, qb.size() + 200));
    refresh();
  endtask

  // Advance n clock cycles; the FIFO pops on each edge where the DUT asserted deq.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (deq_seen_a && qa.size() > 0) void'(qa.pop_front());
      if (deq_seen_b && qb.size() > 0) void'(qb.pop_front());
      refresh();
    end
  endtask

  task automatic modelStep(input int k, input logic [33:0] pkt, input logic emp,
                           input logic [3:0] g, input int act_reqo, input logic act_deq,
                           input int act_cnt);
    int exp_reqo;
    bit exp_deq;
    int flow;
    int dest;
    int p;
    string tag;
    tag = (k == 0) ? "a" : "b";
    exp_reqo = (m_port[k] >= 0) ? (1 << m_port[k]) : 0;
    checkVal({"reqo_", tag}, act_reqo, exp_reqo);
    checkVal({"drop_cnt_", tag}, act_cnt, m_cnt[k]);
    flow = int'(pkt[33:32]);
    dest = int'(pkt[1:0]);
    exp_deq = 1'b0;
    if (rst) begin
      m_port[k] = -1;
      m_drop[k] = 1'b0;
      m_head[k] = 1'b0;
      m_cnt[k]  = 0;
      for (int i = 0; i < 4; i++) m_tbl[k][i] = i % np[k];
    end else begin
      if (m_port[k] >= 0) begin
        exp_deq = !emp && g[m_port[k]];
        if (exp_deq) begin
          if (flow == 3 && m_head[k]) begin
            m_port[k] = -1;
            m_head[k] = 1'b0;
          end else begin
            m_head[k] = 1'b1;
          end
        end
      end else if (m_drop[k]) begin
        exp_deq = !emp;
        if (exp_deq && flow == 3) m_drop[k] = 1'b0;
      end else if (!emp) begin
        p = (md[k] == 1) ? m_tbl[k][dest] : dest;
        if (flow == 1 && p < np[k]) begin
          m_port[k] = p;
        end else begin
          exp_deq = 1'b1;
          if (m_cnt[k] < 255) m_cnt[k]++;
          if (flow == 1) m_drop[k] = 1'b1;
        end
      end
      if (md[k] == 1 && cfg_we) m_tbl[k][cfg_addr] = int'(cfg_port);
    end
    checkVal({"deq_", tag}, act_deq, exp_deq);
  endtask

  task automatic checkOutput();
    modelStep(0, pkto_a, empty_a, gnt_a, int'(reqo_a), deq_a, int'(drop_a));
    modelStep(1, pkto_b, empty_b, {1'b0, gnt_b}, int'(reqo_b), deq_b, int'(drop_b));
  endtask

  always @(negedge clk) begin
    deq_seen_a = deq_a;
    deq_seen_b = deq_b;
    if (run_chk) checkOutput();
  end

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = 2'd0;
    cfg_port = 2'd0;
    gnt_a = 4'b0000;
    gnt_b = 3'b000;
    refresh();
    applyStimulus(2);
    run_chk = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    #1;
    checkVal("reset_reqo_a", int'(reqo_a), 0);
    checkVal("reset_drop_a", int'(drop_a), 0);

    $display("[TB] basic packet with grant stall");
    pushA(2'b01, 2'd2); pushA(2'b10, 2'd0); pushA(2'b10, 2'd0); pushA(2'b11, 2'd0);
    #1 checkVal("head_wait_deq", int'(deq_a), 0);
    applyStimulus(1);
    checkVal("reqo_after_head", int'(reqo_a), 4);
    gnt_a = 4'b0100;
    applyStimulus(2);
    gnt_a = 4'b0000;
    #1 checkVal("stall_deq", int'(deq_a), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkVal("stall_reqo", int'(reqo_a), 4);
    end
    gnt_a = 4'b0100;
    applyStimulus(2);
    checkVal("reqo_after_tail", int'(reqo_a), 0);
    checkVal("fifo_drained_a", qa.size(), 0);
    gnt_a = 4'b0000;

    $display("[TB] foreign grant, empty gap, back-to-back packets");
    pushA(2'b01, 2'd1); pushA(2'b11, 2'd0);
    gnt_a = 4'b0001;
    applyStimulus(3);
    checkVal("foreign_gnt_no_pop", qa.size(), 2);
    gnt_a = 4'b0010;
    applyStimulus(2);
    pushA(2'b01, 2'd0);
    gnt_a = 4'b0001;
    applyStimulus(4);
    checkVal("empty_gap_reqo", int'(reqo_a), 1);
    pushA(2'b11, 2'd0);
    applyStimulus(2);
    gnt_a = 4'b1001;
    pushA(2'b01, 2'd3); pushA(2'b11, 2'd0); pushA(2'b01, 2'd0); pushA(2'b11, 2'd0);
    applyStimulus(8);
    gnt_a = 4'b0000;

    $display("[TB] routing table writes");
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_port = 2'd3;
    applyStimulus(1);
    cfg_we = 1'b0;
    pushA(2'b01, 2'd1); pushA(2'b11, 2'd0);
    applyStimulus(1);
    checkVal("table_route", int'(reqo_a), 8);
    gnt_a = 4'b1000;
    applyStimulus(2);
    gnt_a = 4'b0000;
    pushA(2'b01, 2'd1); pushA(2'b11, 2'd0);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_port = 2'd0;
    applyStimulus(1);
    cfg_we = 1'b0;
    checkVal("same_cycle_old_entry", int'(reqo_a), 8);
    gnt_a = 4'b1000;
    applyStimulus(2);
    gnt_a = 4'b0000;
    pushA(2'b01, 2'd1); pushA(2'b11, 2'd0);
    applyStimulus(1);
    checkVal("new_entry_route", int'(reqo_a), 1);
    gnt_a = 4'b0001;
    applyStimulus(2);
    gnt_a = 4'b0000;

    $display("[TB] unroutable destination on NPORT=3");
    pushB(2'b01, 2'd3); pushB(2'b10, 2'd0); pushB(2'b11, 2'd0);
    applyStimulus(1);
    checkVal("drop_no_reqo", int'(reqo_b), 0);
    applyStimulus(2);
    checkVal("drop_cnt_b_one", int'(drop_b), 1);
    checkVal("drop_fifo_drained", qb.size(), 0);
    pushB(2'b01, 2'd2); pushB(2'b11, 2'd0);
    gnt_b = 3'b100;
    applyStimulus(3);
    checkVal("b_valid_pkt_done", qb.size(), 0);
    gnt_b = 3'b000;

    $display("[TB] reset mid-packet");
    pushA(2'b01, 2'd2); pushA(2'b10, 2'd0); pushA(2'b11, 2'd0);
    gnt_a = 4'b0100;
    applyStimulus(3);
    rst = 1'b1;
    #1 checkVal("reset_cycle_deq", int'(deq_a), 0);
    applyStimulus(1);
    rst = 1'b0;
    checkVal("post_reset_reqo", int'(reqo_a), 0);
    checkVal("post_reset_drop", int'(drop_a), 0);
    applyStimulus(1);
    checkVal("stray_tail_drop", int'(drop_a), 1);
    gnt_a = 4'b0000;

    $display("[TB] stray BODY flood");
    for (int i = 0; i < 300; i++) pushA(2'b10, 2'd0);
    applyStimulus(301);
    checkVal("drop_saturated", int'(drop_a), 255);
    checkVal("flood_drained", qa.size(), 0);

    applyStimulus(2);
    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
